conv_mac_seq: RTL and testbench
===============================

Name: conv_mac_seq

Overview:
Parametrised single-MAC 2-D convolution engine, the generalised successor of the fixed 4x4/3x3 single-PE convolver.
- Snapshots an IN_DIM x IN_DIM feature map and a K x K kernel on start.
- Computes every valid window sequentially, one tap per cycle.
- Streams each requantised result over a valid/ready output port, so the consumer can apply backpressure.
- Supports correlation or true (flipped-kernel) convolution, signed or unsigned operands, and a programmable right shift with optional saturation.

Parameters:
DATA_W, 8, operand width (ifmap and kernel elements)
IN_DIM, 4, ifmap side length
K, 3, kernel side length; constraint K <= IN_DIM
ACC_W, 20, accumulator width; constraint ACC_W >= 2*DATA_W + clog2(K*K)
OUT_W, 8, result width
SIGNED, 0, 1 = two's-complement operands and arithmetic shift; 0 = unsigned
Derived: OUT_DIM = IN_DIM-K+1; IDX_W = max(1, clog2(OUT_DIM*OUT_DIM))

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  begin job; sampled only in IDLE
ifmap  in  IN_DIM*IN_DIM*DATA_W  element (r,c) at [(r*IN_DIM+c)*DATA_W +: DATA_W]
kernel  in  K*K*DATA_W  element (i,j) at [(i*K+j)*DATA_W +: DATA_W]
conv_mode  in  1  0 = correlation, 1 = convolution (kernel index K*K-1-tap)
sat_en  in  1  1 = saturate to OUT_W, 0 = keep low OUT_W bits
shift  in  5  right-shift applied to accumulator before saturation/truncation
busy  out  1  high in every state except IDLE
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  OUT_W  requantised window result
out_idx  out  IDX_W  window index, row-major r*OUT_DIM+c
done  out  1  one-cycle pulse after the last result handshake

Behaviour:
- Reset (async, any state) values: state = IDLE, busy = 0, out_valid = 0, out_data = 0, out_idx = 0, done = 0; accumulator, tap and window counters cleared.
- Reset mid-job abandons the job. No output appears until a new start.
- States: IDLE, MAC, DRAIN, OUT, DONE.
- IDLE: on start=1, the same edge captures ifmap, kernel, conv_mode, sat_en and shift into internal registers, clears acc, sets tap=0 and win=0, and moves to MAC. Later input changes do not affect the job.
- MAC: each cycle registers the product of ifmap(r+i, c+j) and the selected kernel tap into the product register. i = tap/K, j = tap%K; (r,c) is the current window origin.
  - acc accumulates the previous cycle's product.
  - After tap K*K-1, go to DRAIN.
- DRAIN: one cycle; the last product is added to acc; go to OUT.
- OUT: the requantised value is registered into out_data and out_valid is asserted; out_idx = win.
  - out_data and out_idx stay stable while out_valid=1 and out_ready=0.
  - Handshake (valid & ready at an edge): if win = OUT_DIM^2-1, go to DONE; otherwise win+1, acc=0, tap=0, back to MAC.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE or any busy state is ignored.
- Arithmetic:
  - Products are 2*DATA_W wide, sign-extended if SIGNED, into ACC_W.
  - shifted = acc >> shift (arithmetic if SIGNED).
  - sat_en=1 clamps to [0, 2^OUT_W-1] when unsigned, or [-2^(OUT_W-1), 2^(OUT_W-1)-1] when signed.
  - sat_en=0 takes shifted[OUT_W-1:0].
  - shift >= ACC_W yields 0 (or -1 for a negative signed acc).
- Timing with no backpressure: K*K+2 cycles per window. done rises OUT_DIM^2*(K*K+2) cycles after the start-accept edge; 44 cycles for the defaults.
- Each cycle of out_ready=0 in OUT adds exactly one cycle. No accumulation occurs while stalled.
- K = IN_DIM gives a single window with out_idx = 0.

Test Plan:
1. Defaults, ifmap all 1, kernel all 1, shift 0, out_ready=1 -> out_data 9,9,9,9 with out_idx 0..3, one result per 11 cycles; done pulse 44 cycles after start; busy low the cycle after done.
2. ifmap 1..16 row-major, kernel with only (0,0)=1 -> conv_mode=0 outputs 1,2,5,6; conv_mode=1 outputs 11,12,15,16.
3. Unsigned, ifmap all 200, kernel all 200 (acc=360000):
   - sat_en=1, shift=0 -> 255
   - sat_en=0, shift=0 -> 64
   - shift=8, sat_en=1 -> 255
   - shift=8, sat_en=0 -> 126
4. out_ready held low 20 cycles on window 1 -> out_valid stays high, out_data and out_idx stable; done delayed to cycle 64; results unchanged.
5. start pulsed while busy -> ignored, results unchanged. Assert rst during MAC of window 2 -> all outputs 0 immediately; a new start then produces a full, correct 4-result job.
6. SIGNED=1, ifmap all 0xFF (-1), kernel all 2 -> 0xEE (-18); shift=1 -> 0xF7 (-9); ifmap all 0x80 and kernel all 0x80 with sat_en=1 -> 0x7F.

Source files
------------

// File: rtl/conv_mac_seq.sv
// conv_mac_seq -- single-MAC 2-D convolution engine.
//
// Snapshots an IN_DIM x IN_DIM feature map and a K x K kernel on start.
// It then walks every valid window in row-major order and computes one tap
// per cycle. Each window result is requantised (right shift, then saturate
// or truncate) and streamed over a valid/ready port.
//
// Ports:
//   clk, rst    clock; asynchronous active-high reset
//   start       begin a job (sampled only while idle)
//   ifmap       feature map, element (r,c) at [(r*IN_DIM+c)*DATA_W +: DATA_W]
//   kernel      kernel, element (i,j) at [(i*K+j)*DATA_W +: DATA_W]
//   conv_mode   0 = correlation, 1 = convolution (flipped kernel)
//   sat_en      1 = saturate to OUT_W, 0 = keep low OUT_W bits
//   shift       right shift applied to the accumulator before requantising
//   busy        high whenever a job is in progress
//   out_valid   result available on out_data/out_idx
//   out_ready   consumer accepts the result
//   out_data    requantised window result
//   out_idx     window index, row-major r*OUT_DIM+c
//   done        one-cycle pulse after the last result handshake
module conv_mac_seq #(
  parameter int DATA_W = 8,
  parameter int IN_DIM = 4,
  parameter int K      = 3,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8,
  parameter int SIGNED = 0,
  localparam int OUT_DIM = IN_DIM - K + 1,
  localparam int IDX_W   = (OUT_DIM * OUT_DIM > 1) ? $clog2(OUT_DIM * OUT_DIM) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [IN_DIM*IN_DIM*DATA_W-1:0]   ifmap,
  input  logic [K*K*DATA_W-1:0]             kernel,
  input  logic                              conv_mode,
  input  logic                              sat_en,
  input  logic [4:0]                        shift,
  output logic                              busy,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_W-1:0]                  out_data,
  output logic [IDX_W-1:0]                  out_idx,
  output logic                              done
);

  localparam int TAPS  = K * K;
  localparam int NWIN  = OUT_DIM * OUT_DIM;
  localparam int TAP_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int KI_W  = (K > 1) ? $clog2(K) : 1;
  localparam int WR_W  = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  // Saturation bounds expressed at accumulator width (requires ACC_W > OUT_W).
  localparam logic [ACC_W-1:0]        UMAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    OUT,
    DONE
  } state_t;

  state_t state, state_nxt;

  // Job snapshot
  logic [IN_DIM*IN_DIM*DATA_W-1:0] ifmap_q;
  logic [K*K*DATA_W-1:0]           kernel_q;
  logic                            mode_q;
  logic                            sat_q;
  logic [4:0]                      shift_q;

  // Datapath and counters
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod;
  logic [TAP_W-1:0] tap;
  logic [KI_W-1:0]  ki;
  logic [KI_W-1:0]  kj;
  logic [WR_W-1:0]  wr;
  logic [WR_W-1:0]  wc;
  logic [IDX_W-1:0] win;

  // Combinational helpers
  int unsigned                   pix_row;
  int unsigned                   pix_col;
  int unsigned                   kern_idx;
  logic [DATA_W-1:0]             pix_sel;
  logic [DATA_W-1:0]             kern_sel;
  logic signed [2*DATA_W-1:0]    prod_s;
  logic [2*DATA_W-1:0]           prod_u;
  logic [ACC_W-1:0]              prod_ext;
  logic [ACC_W-1:0]              sum;
  logic [ACC_W-1:0]              shifted;
  logic signed [ACC_W-1:0]       shifted_s;
  logic [OUT_W-1:0]              req;

  logic last_tap;
  logic last_kcol;
  logic last_win;
  logic last_wcol;

  assign last_tap  = (tap == TAP_W'(TAPS - 1));
  assign last_kcol = (kj == KI_W'(K - 1));
  assign last_win  = (win == IDX_W'(NWIN - 1));
  assign last_wcol = (wc == WR_W'(OUT_DIM - 1));

  // Operand selection and product for the current tap.
  always_comb begin
    pix_row  = int'(wr) + int'(ki);
    pix_col  = int'(wc) + int'(kj);
    kern_idx = mode_q ? (TAPS - 1 - int'(tap)) : int'(tap);
    pix_sel  = ifmap_q[(pix_row * IN_DIM + pix_col) * DATA_W +: DATA_W];
    kern_sel = kernel_q[kern_idx * DATA_W +: DATA_W];
    prod_s   = (2*DATA_W)'($signed(pix_sel)) * (2*DATA_W)'($signed(kern_sel));
    prod_u   = (2*DATA_W)'(pix_sel) * (2*DATA_W)'(kern_sel);
    if (SIGNED != 0) prod_ext = ACC_W'(prod_s);
    else             prod_ext = ACC_W'(prod_u);
  end

  // Requantisation of the final window sum. In DRAIN the last product has not
  // reached acc yet, so the result is taken from acc + prod directly; this keeps
  // the window at K*K+2 cycles.
  always_comb begin
    sum = acc + prod;
    if (int'(shift_q) >= ACC_W) begin
      shifted = ((SIGNED != 0) && sum[ACC_W-1]) ? '1 : '0;
    end else if (SIGNED != 0) begin
      shifted = $signed(sum) >>> shift_q;
    end else begin
      shifted = sum >> shift_q;
    end
    shifted_s = shifted;

    req = shifted[OUT_W-1:0];
    if (sat_q) begin
      if (SIGNED != 0) begin
        if (shifted_s > SMAX)      req = SMAX[OUT_W-1:0];
        else if (shifted_s < SMIN) req = SMIN[OUT_W-1:0];
      end else begin
        if (shifted > UMAX)        req = '1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = last_win ? DONE : MAC;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == OUT);
  assign done      = (state == DONE);

  // Datapath, snapshot and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifmap_q  <= '0;
      kernel_q <= '0;
      mode_q   <= 1'b0;
      sat_q    <= 1'b0;
      shift_q  <= '0;
      acc      <= '0;
      prod     <= '0;
      tap      <= '0;
      ki       <= '0;
      kj       <= '0;
      wr       <= '0;
      wc       <= '0;
      win      <= '0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            ifmap_q  <= ifmap;
            kernel_q <= kernel;
            mode_q   <= conv_mode;
            sat_q    <= sat_en;
            shift_q  <= shift;
            acc      <= '0;
            prod     <= '0;
            tap      <= '0;
            ki       <= '0;
            kj       <= '0;
            wr       <= '0;
            wc       <= '0;
            win      <= '0;
          end
        end
        MAC: begin
          // prod is cleared at window start, so tap 0 adds nothing stale.
          prod <= prod_ext;
          acc  <= sum;
          tap  <= tap + 1'b1;
          if (last_kcol) begin
            kj <= '0;
            ki <= ki + 1'b1;
          end else begin
            kj <= kj + 1'b1;
          end
        end
        DRAIN: begin
          acc      <= sum;
          out_data <= req;
          out_idx  <= win;
        end
        OUT: begin
          if (out_ready) begin
            acc  <= '0;
            prod <= '0;
            tap  <= '0;
            ki   <= '0;
            kj   <= '0;
            if (!last_win) begin
              win <= win + 1'b1;
              if (last_wcol) begin
                wc <= '0;
                wr <= wr + 1'b1;
              end else begin
                wc <= wc + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_seq.sv
// tb_conv_mac_seq -- directed bench for conv_mac_seq.
// Three instances: default unsigned, SIGNED=1, and K=IN_DIM (single window).
// Expected results are queued when a job is launched and popped on every
// output handshake.
module tb_conv_mac_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start0, start1, start2;
  logic [127:0] ifmap;
  logic [71:0]  kernel3;
  logic [127:0] kernel4;
  logic         conv_mode, sat_en, out_ready;
  logic [4:0]   shift;

  logic       busy0, valid0, done0;
  logic [7:0] data0;
  logic [1:0] idx0;
  logic       busy1, valid1, done1;
  logic [7:0] data1;
  logic [1:0] idx1;
  logic       busy2, valid2, done2;
  logic [7:0] data2;
  logic [0:0] idx2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  conv_mac_seq u_dut (
    .clk(clk), .rst(rst), .start(start0), .ifmap(ifmap), .kernel(kernel3),
    .conv_mode(conv_mode), .sat_en(sat_en), .shift(shift), .busy(busy0),
    .out_valid(valid0), .out_ready(out_ready), .out_data(data0), .out_idx(idx0),
    .done(done0)
  );

  conv_mac_seq #(.SIGNED(1)) u_dut_s (
    .clk(clk), .rst(rst), .start(start1), .ifmap(ifmap), .kernel(kernel3),
    .conv_mode(conv_mode), .sat_en(sat_en), .shift(shift), .busy(busy1),
    .out_valid(valid1), .out_ready(out_ready), .out_data(data1), .out_idx(idx1),
    .done(done1)
  );

  conv_mac_seq #(.K(4)) u_dut_k4 (
    .clk(clk), .rst(rst), .start(start2), .ifmap(ifmap), .kernel(kernel4),
    .conv_mode(conv_mode), .sat_en(sat_en), .shift(shift), .busy(busy2),
    .out_valid(valid2), .out_ready(out_ready), .out_data(data2), .out_idx(idx2),
    .done(done2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: one window result, computed from scratch.
  function automatic int model(input logic [127:0] fm, input logic [127:0] kn,
                               input int k, input int r, input int c, input bit mode,
                               input bit sat, input int sh, input bit sgn);
    longint acc, a, b, v;
    int t, kt;
    logic [7:0] ab, bb;
    acc = 0;
    for (int i = 0; i < k; i++) begin
      for (int j = 0; j < k; j++) begin
        t  = i * k + j;
        kt = mode ? (k * k - 1 - t) : t;
        ab = fm[((r + i) * 4 + (c + j)) * 8 +: 8];
        bb = kn[kt * 8 +: 8];
        if (sgn) begin
          a = longint'($signed(ab));
          b = longint'($signed(bb));
        end else begin
          a = longint'(ab);
          b = longint'(bb);
        end
        acc += a * b;
      end
    end
    if (sh >= 20) v = (acc < 0) ? -1 : 0;
    else          v = acc >>> sh;
    if (sat) begin
      if (sgn) begin
        if (v > 127)       v = 127;
        else if (v < -128) v = -128;
      end else if (v > 255) begin
        v = 255;
      end
    end
    return int'(v & 255);
  endfunction

  task automatic mon();
    int e;
    if (rst === 1'b0 && out_ready === 1'b1) begin
      if (valid0 === 1'b1) begin
        chk("dut0 result expected", 32'(q0.size() > 0), 1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("dut0 out_data", 32'(data0), e & 255);
          chk("dut0 out_idx", 32'(idx0), e >> 8);
        end
      end
      if (valid1 === 1'b1) begin
        chk("dut_s result expected", 32'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("dut_s out_data", 32'(data1), e & 255);
          chk("dut_s out_idx", 32'(idx1), e >> 8);
        end
      end
      if (valid2 === 1'b1) begin
        chk("dut_k4 result expected", 32'(q2.size() > 0), 1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          chk("dut_k4 out_data", 32'(data2), e & 255);
          chk("dut_k4 out_idx", 32'(idx2), e >> 8);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  function automatic logic busy_of(input int d);
    return (d == 0) ? busy0 : (d == 1) ? busy1 : busy2;
  endfunction

  function automatic logic done_of(input int d);
    return (d == 0) ? done0 : (d == 1) ? done1 : done2;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
  endfunction

  task automatic push(input int d, input int idx, input int v);
    case (d)
      0:       q0.push_back(idx * 256 + v);
      1:       q1.push_back(idx * 256 + v);
      default: q2.push_back(idx * 256 + v);
    endcase
  endtask

  task automatic push_const(input int d, input int v);
    int n;
    n = (d == 2) ? 1 : 4;
    for (int w = 0; w < n; w++) push(d, w, v);
  endtask

  task automatic push4(input int d, input int a, input int b, input int c, input int e);
    push(d, 0, a);
    push(d, 1, b);
    push(d, 2, c);
    push(d, 3, e);
  endtask

  task automatic push_model(input int d);
    int k, nd;
    logic [127:0] kn;
    k  = (d == 2) ? 4 : 3;
    nd = 5 - k;
    kn = (d == 2) ? kernel4 : {56'b0, kernel3};
    for (int r = 0; r < nd; r++)
      for (int c = 0; c < nd; c++)
        push(d, r * nd + c, model(ifmap, kn, k, r, c, conv_mode, sat_en, int'(shift), d == 1));
  endtask

  task automatic begin_job(input int d, output int c0);
    case (d)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    c0 = cyc;
    chk("busy after start", 32'(busy_of(d)), 1);
  endtask

  task automatic finish_job(input int d, input int c0, input int lat);
    bit got;
    got = 0;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (done_of(d) === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("done seen", 32'(got), 1);
    if (got) chk("done latency", cyc - c0, lat);
    tick();
    chk("busy after done", 32'(busy_of(d)), 0);
    chk("done one cycle", 32'(done_of(d)), 0);
    chk("all results delivered", qsize(d), 0);
  endtask

  task automatic run_job(input int d, input int lat);
    int c0;
    begin_job(d, c0);
    finish_job(d, c0, lat);
  endtask

  task automatic fill(input logic [7:0] fv, input logic [7:0] kv);
    for (int n = 0; n < 16; n++) ifmap[n * 8 +: 8] = fv;
    for (int n = 0; n < 9; n++) kernel3[n * 8 +: 8] = kv;
  endtask

  task automatic rand_data();
    ifmap   = {$urandom(), $urandom(), $urandom(), $urandom()};
    kernel3 = 72'({$urandom(), $urandom(), $urandom()});
  endtask

  initial begin
    int c0;
    bit got, sawv;

    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    ifmap = '0; kernel3 = '0; kernel4 = '0;
    conv_mode = 1'b0; sat_en = 1'b0; shift = '0; out_ready = 1'b1;
    #1;
    chk("reset busy", 32'(busy0), 0);
    chk("reset out_valid", 32'(valid0), 0);
    chk("reset out_data", 32'(data0), 0);
    chk("reset out_idx", 32'(idx0), 0);
    chk("reset done", 32'(done0), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // All ones: each window sums nine ones.
    fill(8'd1, 8'd1);
    sat_en = 1'b1;
    push_const(0, 9);
    run_job(0, 44);

    // Single-tap kernel picks out one pixel per window.
    for (int n = 0; n < 16; n++) ifmap[n * 8 +: 8] = 8'(n + 1);
    kernel3 = '0;
    kernel3[7:0] = 8'd1;
    conv_mode = 1'b0;
    push4(0, 1, 2, 5, 6);
    run_job(0, 44);
    conv_mode = 1'b1;
    push4(0, 11, 12, 15, 16);
    run_job(0, 44);

    // acc = 360000: saturate/truncate with and without shift.
    conv_mode = 1'b0;
    fill(8'd200, 8'd200);
    sat_en = 1'b1; shift = 5'd0; push_const(0, 255); run_job(0, 44);
    sat_en = 1'b0; shift = 5'd0; push_const(0, 64);  run_job(0, 44);
    sat_en = 1'b1; shift = 5'd8; push_const(0, 255); run_job(0, 44);
    sat_en = 1'b0; shift = 5'd8; push_const(0, 126); run_job(0, 44);

    // Backpressure: hold window 1 for 20 cycles.
    fill(8'd1, 8'd1);
    sat_en = 1'b1; shift = 5'd0;
    push_const(0, 9);
    begin_job(0, c0);
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      if (valid0 === 1'b1) got = 1;
    end
    chk("window 0 valid", 32'(got), 1);
    tick();
    out_ready = 1'b0;
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      tick();
      if (valid0 === 1'b1) got = 1;
    end
    chk("window 1 valid", 32'(got), 1);
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("stall out_valid", 32'(valid0), 1);
      chk("stall out_data", 32'(data0), 9);
      chk("stall out_idx", 32'(idx0), 1);
    end
    out_ready = 1'b1;
    mon();
    finish_job(0, c0, 64);

    // start while busy and input changes mid-job are ignored.
    fill(8'd1, 8'd1);
    push_const(0, 9);
    begin_job(0, c0);
    repeat (5) tick();
    start0 = 1'b1;
    ifmap = '0;
    repeat (3) tick();
    start0 = 1'b0;
    finish_job(0, c0, 44);

    // Reset during window 2 abandons the job.
    rand_data();
    conv_mode = 1'b1; sat_en = 1'b1; shift = 5'd4;
    push_model(0);
    begin_job(0, c0);
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      tick();
      if (valid0 === 1'b1 && idx0 === 2'd1) got = 1;
    end
    chk("window 1 reached", 32'(got), 1);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk("mid-job reset busy", 32'(busy0), 0);
    chk("mid-job reset out_valid", 32'(valid0), 0);
    chk("mid-job reset out_data", 32'(data0), 0);
    chk("mid-job reset out_idx", 32'(idx0), 0);
    chk("mid-job reset done", 32'(done0), 0);
    q0.delete();
    tick();
    rst = 1'b0;
    sawv = 0;
    repeat (30) begin
      tick();
      if (valid0 !== 1'b0 || done0 !== 1'b0) sawv = 1;
    end
    chk("no output after reset", 32'(sawv), 0);
    chk("idle after reset", 32'(busy0), 0);
    rand_data();
    conv_mode = 1'b0; sat_en = 1'b0; shift = 5'd3;
    push_model(0);
    run_job(0, 44);

    // K = IN_DIM: single window, sum of 1..16.
    for (int n = 0; n < 16; n++) ifmap[n * 8 +: 8] = 8'(n + 1);
    for (int n = 0; n < 16; n++) kernel4[n * 8 +: 8] = 8'd1;
    conv_mode = 1'b0; sat_en = 1'b0; shift = 5'd0;
    push(2, 0, 136);
    run_job(2, 18);

    // Signed operands.
    fill(8'hFF, 8'd2);
    sat_en = 1'b1; shift = 5'd0; push_const(1, 8'hEE); run_job(1, 44);
    shift = 5'd1; push_const(1, 8'hF7); run_job(1, 44);
    fill(8'h80, 8'h80);
    shift = 5'd0; push_const(1, 8'h7F); run_job(1, 44);
    rand_data();
    conv_mode = 1'b1; sat_en = 1'b0; shift = 5'd2;
    push_model(1);
    run_job(1, 44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
